alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, pipelined integer ALU; successor to the single-cycle combinational ALU in the execute stage.
- Adds configurable XLEN, configurable pipeline depth, valid/ready handshaking with backpressure, flush, transaction-ID passthrough and RV64 word ops.
- Sits between issue and writeback as a functional unit with throughput of one operation per cycle.

Parameters:
- XLEN, 64, operand/result width; legal values 32 or 64. Word ops are legal only when XLEN=64.
- STAGES, 2, number of register stages from input to output; legal range 1..4.
- TRANS_ID_W, 3, width of the transaction tag.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  kill all in-flight ops.
- in_valid_i  in  1  input op valid.
- in_ready_o  out  1  unit can accept an op.
- op_i  in  5  operator, of type alu_pkg::alu_op_e.
- operand_a_i  in  XLEN  rs1 value.
- operand_b_i  in  XLEN  rs2 value or immediate.
- trans_id_i  in  TRANS_ID_W  issue tag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  writeback accepts the result.
- result_o  out  XLEN  result.
- branch_o  out  1  branch condition outcome.
- trans_id_o  out  TRANS_ID_W  tag of the result.
- illegal_o  out  1  unsupported opcode was executed.

Behaviour:
- Reset (rst_i=1 at a clock edge): every stage valid bit clears. Outputs then read out_valid_o=0, result_o=0, branch_o=0, trans_id_o=0, illegal_o=0, in_ready_o=1.
- Reset mid-operation: all in-flight ops are discarded with no output.
- Compute:
  - Combinational compute happens before stage 1.
  - Stages 2..STAGES carry the registered result, branch, tag and illegal bits.
  - Latency is exactly STAGES cycles from an input handshake to out_valid_o when there is no stall.
- Handshake:
  - A transfer occurs when valid and ready are both 1 on the same edge.
  - Stage k advances when stage k+1 is empty or stage k+1 is advancing.
  - The last stage advances when out_ready_i=1.
  - in_ready_o = !flush_i && (stage1 empty || stage1 advancing).
  - Full throughput is one op per cycle; bubbles squeeze out under stall.
  - Outputs are held stable while out_valid_o=1 and out_ready_i=0.
- Flush: when flush_i=1, all valid bits clear at the next edge and no input is accepted that cycle. If flush_i and rst_i are both high, reset applies; the result is identical.
- Operators (alu_op_e encoding):
  - ADD=0, SUB=1.
  - XORL=2, ORL=3, ANDL=4.
  - SLL=5, SRL=6, SRA=7.
  - SLTS=8, SLTU=9.
  - EQ=10, NE=11, LTS=12, GES=13, LTU=14, GEU=15.
  - ADDW=16, SUBW=17, SLLW=18, SRLW=19, SRAW=20.
  - ANDN=21, ORN=22, XNOR=23, MIN=24, MAX=25, MINU=26, MAXU=27, CPOP=28.
- Arithmetic and width rules:
  - Shift amount for XLEN shifts = operand_b[$clog2(XLEN)-1:0].
  - Word ops use operand_a[31:0]/operand_b[31:0] and shift amount b[4:0]; the 32-bit result is sign-extended to XLEN.
  - ADD/SUB wrap modulo 2^XLEN.
- Compare/branch results:
  - SLTS/SLTU: result = 1 or 0, zero-extended; branch_o=0.
  - EQ..GEU: branch_o = condition; result=0.
  - All other ops: branch_o=0.
- Illegal ops:
  - Word ops with XLEN=32, and opcodes 29..31, give result=0, branch_o=0, illegal_o=1.
  - The op still flows and handshakes normally.

Optional Feature:
- Macro: ALU_PIPE_BITMANIP_EN.
- Defined: ANDN/ORN/XNOR/MIN/MAX/MINU/MAXU/CPOP are implemented.
  - CPOP result = population count of operand_a, zero-extended.
  - MIN/MAX are signed; MINU/MAXU are unsigned.
- Undefined: opcodes 21..28 are treated as illegal (result=0, illegal_o=1). No bitmanip logic is synthesised.

Decomposition:
- alu_pkg holds the alu_op_e enum and the helper function is_word_op().
- alu_pkg also holds the pipeline payload struct: result, branch, trans_id, illegal.
- Sub-module alu_core: purely combinational operator datapath, parametrised by XLEN.
- alu_pipe instantiates alu_core and owns the stage registers and handshake logic.

Test Plan:
- Streaming: XLEN=64, STAGES=2, ADD a=1,b=2 (tag 5), then SUB a=1,b=2 (tag 6) on consecutive cycles with out_ready_i=1.
  -> Results 3 then 0xFFFF_FFFF_FFFF_FFFF with tags 5,6, at cycles +2 and +3.
- Word ops: ADDW a=0x7FFF_FFFF,b=1 -> 0xFFFF_FFFF_8000_0000; SRAW a=0x8000_0000,b=36 -> 0xFFFF_FFFF_F800_0000; SRA a=0x8000_0000_0000_0000,b=1 -> 0xC000_0000_0000_0000.
- Branch/compare: LTU a=1,b=0xFFFF_FFFF_FFFF_FFFF -> branch_o=1, result=0; LTS same operands -> branch_o=0; SLTS a=-1,b=2 -> result=1.
- Backpressure: hold out_ready_i=0 and issue 3 ops. in_ready_o drops after STAGES ops are accepted, and outputs stay stable. Releasing out_ready_i drains the ops in order, with no loss and no duplication.
- Flush and reset mid-flight: 2 ops in flight, assert flush_i for 1 cycle -> out_valid_o=0 next cycle and neither op appears. Repeat with rst_i -> all outputs read 0.
- Feature and illegal ops:
  - With ALU_PIPE_BITMANIP_EN: CPOP a=0xF0F0 -> 8; MINU a=3,b=-1 -> 3.
  - Without the macro: CPOP -> result=0, illegal_o=1.
  - With XLEN=32: ADDW -> illegal_o=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: operator encoding, word-op helper and
// the payload carried through every pipeline stage.
package alu_pkg;

    localparam int XLEN_MAX  = 64;
    localparam int TID_W_MAX = 8;

    typedef enum logic [4:0] {
        ADD  = 5'd0,  SUB  = 5'd1,
        XORL = 5'd2,  ORL  = 5'd3,  ANDL = 5'd4,
        SLL  = 5'd5,  SRL  = 5'd6,  SRA  = 5'd7,
        SLTS = 5'd8,  SLTU = 5'd9,
        EQ   = 5'd10, NE   = 5'd11, LTS  = 5'd12, GES  = 5'd13, LTU = 5'd14, GEU = 5'd15,
        ADDW = 5'd16, SUBW = 5'd17, SLLW = 5'd18, SRLW = 5'd19, SRAW = 5'd20,
        ANDN = 5'd21, ORN  = 5'd22, XNOR = 5'd23, MIN  = 5'd24, MAX = 5'd25,
        MINU = 5'd26, MAXU = 5'd27, CPOP = 5'd28
    } alu_op_e;

    // Sized for the widest configuration; narrower instances use the low bits.
    typedef struct packed {
        logic [XLEN_MAX-1:0]  result;
        logic                 branch;
        logic [TID_W_MAX-1:0] trans_id;
        logic                 illegal;
    } alu_payload_t;

    function automatic logic is_word_op(alu_op_e op);
        return op inside {ADDW, SUBW, SLLW, SRLW, SRAW};
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Issue/writeback handshake bundle of the pipelined ALU.
interface alu_pipe_if
    import alu_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int TRANS_ID_W = 3
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    alu_op_e               op_i;
    logic [XLEN-1:0]       operand_a_i;
    logic [XLEN-1:0]       operand_b_i;
    logic [TRANS_ID_W-1:0] trans_id_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [XLEN-1:0]       result_o;
    logic                  branch_o;
    logic [TRANS_ID_W-1:0] trans_id_o;
    logic                  illegal_o;

    modport master (
        output in_valid_i, op_i, operand_a_i, operand_b_i, trans_id_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, branch_o, trans_id_o, illegal_o
    );

    modport slave (
        input  in_valid_i, op_i, operand_a_i, operand_b_i, trans_id_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, branch_o, trans_id_o, illegal_o
    );
endinterface

// File: rtl/alu_core.sv
// Combinational operator datapath of the pipelined ALU.
// Bitmanip operators exist only when ALU_PIPE_BITMANIP_EN is defined.
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  alu_op_e         op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] result,
    output logic            branch,
    output logic            illegal
);
    localparam int SHW = $clog2(XLEN);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic signed [31:0]     aw_s;
    logic signed [31:0]     word_res;
    logic                   lts;
    logic                   ltu;
    logic [SHW-1:0]         shamt;

    assign a_s   = operand_a;
    assign b_s   = operand_b;
    assign aw_s  = operand_a[31:0];
    assign lts   = a_s < b_s;
    assign ltu   = operand_a < operand_b;
    assign shamt = operand_b[SHW-1:0];

`ifdef ALU_PIPE_BITMANIP_EN
    function automatic logic [SHW:0] popcount(logic [XLEN-1:0] v);
        logic [SHW:0] cnt;
        cnt = '0;
        for (int i = 0; i < XLEN; i++) cnt = cnt + (SHW+1)'(v[i]);
        return cnt;
    endfunction
`endif

    always_comb begin
        word_res = '0;
        case (op)
            ADDW:    word_res = signed'(operand_a[31:0] + operand_b[31:0]);
            SUBW:    word_res = signed'(operand_a[31:0] - operand_b[31:0]);
            SLLW:    word_res = signed'(operand_a[31:0] << operand_b[4:0]);
            SRLW:    word_res = signed'(operand_a[31:0] >> operand_b[4:0]);
            SRAW:    word_res = aw_s >>> operand_b[4:0];
            default: word_res = '0;
        endcase
    end

    always_comb begin
        result  = '0;
        branch  = 1'b0;
        illegal = 1'b0;
        if (is_word_op(op)) begin
            // 32-bit results are sign-extended; RV32 has no word forms.
            if (XLEN == 64) result = XLEN'(word_res);
            else            illegal = 1'b1;
        end else begin
            case (op)
                ADD:  result = operand_a + operand_b;
                SUB:  result = operand_a - operand_b;
                XORL: result = operand_a ^ operand_b;
                ORL:  result = operand_a | operand_b;
                ANDL: result = operand_a & operand_b;
                SLL:  result = operand_a << shamt;
                SRL:  result = operand_a >> shamt;
                SRA:  result = a_s >>> shamt;
                SLTS: result = XLEN'(lts);
                SLTU: result = XLEN'(ltu);
                EQ:   branch = operand_a == operand_b;
                NE:   branch = operand_a != operand_b;
                LTS:  branch = lts;
                GES:  branch = !lts;
                LTU:  branch = ltu;
                GEU:  branch = !ltu;
`ifdef ALU_PIPE_BITMANIP_EN
                ANDN: result = operand_a & ~operand_b;
                ORN:  result = operand_a | ~operand_b;
                XNOR: result = ~(operand_a ^ operand_b);
                MIN:  result = lts ? operand_a : operand_b;
                MAX:  result = lts ? operand_b : operand_a;
                MINU: result = ltu ? operand_a : operand_b;
                MAXU: result = ltu ? operand_b : operand_a;
                CPOP: result = XLEN'(popcount(operand_a));
`endif
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined integer ALU: alu_core followed by STAGES elastic register stages
// with valid/ready backpressure, flush and transaction-tag passthrough.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int STAGES     = 2,
    parameter int TRANS_ID_W = 3
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     flush_i,
    alu_pipe_if.slave bus
);
    logic [XLEN-1:0] core_result;
    logic            core_branch;
    logic            core_illegal;
    alu_payload_t    pay_p0;
    logic            vld_p0;
    logic            in_ready;

    alu_payload_t    pay_pn [STAGES];
    logic [STAGES-1:0] vld_pn;
    logic [STAGES-1:0] rdy_pn;
    alu_payload_t    pay_out;
    logic            unused_pay;

    alu_core #(.XLEN(XLEN)) u_core (
        .op        (bus.op_i),
        .operand_a (bus.operand_a_i),
        .operand_b (bus.operand_b_i),
        .result    (core_result),
        .branch    (core_branch),
        .illegal   (core_illegal)
    );

    always_comb begin
        pay_p0          = '0;
        pay_p0.result   = XLEN_MAX'(core_result);
        pay_p0.branch   = core_branch;
        pay_p0.trans_id = TID_W_MAX'(bus.trans_id_i);
        pay_p0.illegal  = core_illegal;
    end

    // A stage can take new data when it is empty or its content moves on.
    always_comb begin
        rdy_pn = '0;
        rdy_pn[STAGES-1] = !vld_pn[STAGES-1] || bus.out_ready_i;
        for (int k = STAGES - 2; k >= 0; k--) rdy_pn[k] = !vld_pn[k] || rdy_pn[k+1];
    end

    assign in_ready       = !flush_i && rdy_pn[0];
    assign vld_p0         = bus.in_valid_i && in_ready;
    assign bus.in_ready_o = in_ready;

    // ---- stage 1..STAGES: valid bits (control, reset/flush) ----
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            vld_pn <= '0;
        end else begin
            if (rdy_pn[0]) vld_pn[0] <= vld_p0;
            for (int k = 1; k < STAGES; k++)
                if (rdy_pn[k]) vld_pn[k] <= vld_pn[k-1];
        end
    end

    // ---- stage 1..STAGES: payload (data, loaded only with a valid op) ----
    always_ff @(posedge clk_i) begin
        if (rdy_pn[0] && vld_p0) pay_pn[0] <= pay_p0;
        for (int k = 1; k < STAGES; k++)
            if (rdy_pn[k] && vld_pn[k-1]) pay_pn[k] <= pay_pn[k-1];
    end

    // Outputs read zero whenever the last stage is empty.
    assign pay_out         = pay_pn[STAGES-1];
    assign bus.out_valid_o = vld_pn[STAGES-1];
    assign bus.result_o    = vld_pn[STAGES-1] ? pay_out.result[XLEN-1:0] : '0;
    assign bus.branch_o    = vld_pn[STAGES-1] && pay_out.branch;
    assign bus.trans_id_o  = vld_pn[STAGES-1] ? pay_out.trans_id[TRANS_ID_W-1:0] : '0;
    assign bus.illegal_o   = vld_pn[STAGES-1] && pay_out.illegal;
    assign unused_pay      = ^pay_out;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (XLEN=64, STAGES=2) plus a small XLEN=32 instance.
`timescale 1ns/1ps
module tb_alu_pipe;
    import alu_pkg::*;

    typedef struct {
        logic [63:0] result;
        logic        branch;
        logic [2:0]  tid;
        logic        illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t ez;
    bit   rnd_done;

    always #5 clk = ~clk;

    alu_pipe_if #(.XLEN(64), .TRANS_ID_W(3)) bus ();
    alu_pipe_if #(.XLEN(32), .TRANS_ID_W(3)) bus32 ();

    alu_pipe #(.XLEN(64), .STAGES(2), .TRANS_ID_W(3)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(bus)
    );
    alu_pipe #(.XLEN(32), .STAGES(1), .TRANS_ID_W(3)) dut32 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .bus(bus32)
    );

    // Scoreboard: every accepted output must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (bus.out_valid_o && bus.out_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got result=%h tid=%0d, required no output", bus.result_o, bus.trans_id_o);
            end else begin
                e = exp_q.pop_front();
                if ({bus.result_o, bus.branch_o, bus.trans_id_o, bus.illegal_o} !==
                    {e.result, e.branch, e.tid, e.illegal}) begin
                    errors++;
                    $display("FAIL sb_output: got res=%h br=%b tid=%0d ill=%b, required res=%h br=%b tid=%0d ill=%b",
                             bus.result_o, bus.branch_o, bus.trans_id_o, bus.illegal_o,
                             e.result, e.branch, e.tid, e.illegal);
                end
            end
        end
    end

    function automatic exp_t mk(logic [63:0] r, logic br, logic [2:0] tid, logic ill);
        exp_t e;
        e.result = r; e.branch = br; e.tid = tid; e.illegal = ill;
        return e;
    endfunction

    function automatic exp_t model(alu_op_e op, logic [63:0] a, logic [63:0] b, logic [2:0] tid);
        logic [63:0] r;
        case (op)
            ADD:  r = a + b;
            SUB:  r = a - b;
            XORL: r = a ^ b;
            ORL:  r = a | b;
            ANDL: r = a & b;
            SLL:  r = a << b[5:0];
            default: r = a >> b[5:0];
        endcase
        return mk(r, 1'b0, tid, 1'b0);
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Present one op, wait (bounded) for acceptance, optionally record expectation.
    task automatic send(input alu_op_e op, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] tid, input exp_t e, input bit track);
        int guard = 0;
        bus.in_valid_i = 1'b1; bus.op_i = op;
        bus.operand_a_i = a; bus.operand_b_i = b; bus.trans_id_i = tid;
        @(negedge clk);
        while (!bus.in_ready_o && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 60) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for op %0d tid %0d", op, tid);
        end else if (track) begin
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still outstanding, required 0", exp_q.size());
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        @(negedge clk);
        checks++;
        if ({bus.out_valid_o, bus.result_o, bus.branch_o, bus.trans_id_o, bus.illegal_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: vld=%b res=%h br=%b tid=%0d ill=%b, required all 0",
                     bus.out_valid_o, bus.result_o, bus.branch_o, bus.trans_id_o, bus.illegal_o);
        end
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready_o);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_streaming();
        bus.out_ready_i = 1'b1;
        send(ADD, 64'd1, 64'd2, 3'd5, mk(64'd3, 1'b0, 3'd5, 1'b0), 1'b1);
        send(SUB, 64'd1, 64'd2, 3'd6, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd6, 1'b0), 1'b1);
        @(negedge clk);
        checks++;
        if (bus.out_valid_o !== 1'b1 || bus.trans_id_o !== 3'd5) begin
            errors++;
            $display("FAIL stream_lat_add: vld=%b tid=%0d, required vld=1 tid=5", bus.out_valid_o, bus.trans_id_o);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid_o !== 1'b1 || bus.trans_id_o !== 3'd6) begin
            errors++;
            $display("FAIL stream_lat_sub: vld=%b tid=%0d, required vld=1 tid=6", bus.out_valid_o, bus.trans_id_o);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stream_idle: vld=%b required 0", bus.out_valid_o);
        end
        wait_drain();
    endtask

    task automatic test_word_ops();
        send(ADDW, 64'h7FFF_FFFF, 64'd1, 3'd1, mk(64'hFFFF_FFFF_8000_0000, 1'b0, 3'd1, 1'b0), 1'b1);
        send(SRAW, 64'h8000_0000, 64'd36, 3'd2, mk(64'hFFFF_FFFF_F800_0000, 1'b0, 3'd2, 1'b0), 1'b1);
        send(SRA, 64'h8000_0000_0000_0000, 64'd1, 3'd3, mk(64'hC000_0000_0000_0000, 1'b0, 3'd3, 1'b0), 1'b1);
        send(SLLW, 64'h1, 64'd31, 3'd4, mk(64'hFFFF_FFFF_8000_0000, 1'b0, 3'd4, 1'b0), 1'b1);
        send(SUBW, 64'h0, 64'd1, 3'd5, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd5, 1'b0), 1'b1);
        send(SLL, 64'h1, 64'd65, 3'd6, mk(64'h2, 1'b0, 3'd6, 1'b0), 1'b1);
        wait_drain();
    endtask

    task automatic test_branch();
        send(LTU, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, mk(64'd0, 1'b1, 3'd1, 1'b0), 1'b1);
        send(LTS, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd2, mk(64'd0, 1'b0, 3'd2, 1'b0), 1'b1);
        send(SLTS, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'd3, mk(64'd1, 1'b0, 3'd3, 1'b0), 1'b1);
        send(SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'd4, mk(64'd0, 1'b0, 3'd4, 1'b0), 1'b1);
        send(EQ, 64'd7, 64'd7, 3'd5, mk(64'd0, 1'b1, 3'd5, 1'b0), 1'b1);
        send(GES, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3'd6, mk(64'd0, 1'b0, 3'd6, 1'b0), 1'b1);
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [63:0] hold_res;
        logic [2:0]  hold_tid;
        bus.out_ready_i = 1'b0;
        fork
            begin
                send(ADD, 64'd100, 64'd1, 3'd1, mk(64'd101, 1'b0, 3'd1, 1'b0), 1'b1);
                send(XORL, 64'hFF, 64'h0F, 3'd2, mk(64'hF0, 1'b0, 3'd2, 1'b0), 1'b1);
                send(ORL, 64'hA0, 64'h05, 3'd3, mk(64'hA5, 1'b0, 3'd3, 1'b0), 1'b1);
            end
            begin
                repeat (3) @(negedge clk);
                checks++;
                if (bus.in_ready_o !== 1'b0 || bus.out_valid_o !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_full: in_ready=%b out_valid=%b, required 0 and 1", bus.in_ready_o, bus.out_valid_o);
                end
                hold_res = bus.result_o;
                hold_tid = bus.trans_id_o;
                checks++;
                if (hold_res !== 64'd101 || hold_tid !== 3'd1) begin
                    errors++;
                    $display("FAIL bp_head: res=%h tid=%0d, required 65 tid 1", hold_res, hold_tid);
                end
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (bus.result_o !== hold_res || bus.trans_id_o !== hold_tid || bus.out_valid_o !== 1'b1) begin
                        errors++;
                        $display("FAIL bp_stable: res=%h tid=%0d vld=%b, required %h tid %0d vld 1",
                                 bus.result_o, bus.trans_id_o, bus.out_valid_o, hold_res, hold_tid);
                    end
                end
                step();
                bus.out_ready_i = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_back_to_back();
        alu_op_e ops [7] = '{ADD, SUB, XORL, ORL, ANDL, SLL, SRL};
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    alu_op_e op;
                    logic [63:0] a, b;
                    op = ops[$urandom_range(0, 6)];
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom};
                    send(op, a, b, 3'(i), model(op, a, b, 3'(i)), 1'b1);
                    if ($urandom_range(0, 3) == 0) step();
                end
                wait_drain();
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    step();
                    bus.out_ready_i = ($urandom_range(0, 2) != 0);
                end
                bus.out_ready_i = 1'b1;
            end
        join
        step();
    endtask

    task automatic test_flush_reset();
        bus.out_ready_i = 1'b0;
        send(ADD, 64'd10, 64'd20, 3'd1, ez, 1'b0);
        send(SUB, 64'd10, 64'd20, 3'd2, ez, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %b required 0", bus.in_ready_o);
        end
        step();
        flush = 1'b0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.result_o !== 64'd0) begin
            errors++;
            $display("FAIL flush_out: vld=%b res=%h, required 0", bus.out_valid_o, bus.result_o);
        end
        repeat (4) @(negedge clk);
        step();
        bus.out_ready_i = 1'b0;
        send(ANDL, 64'hFF, 64'h0F, 3'd3, ez, 1'b0);
        send(ORL, 64'hF0, 64'h0F, 3'd4, ez, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.out_valid_o, bus.result_o, bus.branch_o, bus.trans_id_o, bus.illegal_o} !== '0 ||
            bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_midflight: vld=%b res=%h br=%b tid=%0d ill=%b rdy=%b, required zeros and rdy 1",
                     bus.out_valid_o, bus.result_o, bus.branch_o, bus.trans_id_o, bus.illegal_o, bus.in_ready_o);
        end
        step();
        bus.out_ready_i = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_illegal();
        alu_op_e bad;
        bad = alu_op_e'(5'd29);
        send(bad, 64'd5, 64'd6, 3'd1, mk(64'd0, 1'b0, 3'd1, 1'b1), 1'b1);
`ifdef ALU_PIPE_BITMANIP_EN
        send(CPOP, 64'hF0F0, 64'd0, 3'd2, mk(64'd8, 1'b0, 3'd2, 1'b0), 1'b1);
        send(MINU, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, mk(64'd3, 1'b0, 3'd3, 1'b0), 1'b1);
        send(MIN, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3'd4, mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd4, 1'b0), 1'b1);
`else
        send(CPOP, 64'hF0F0, 64'd0, 3'd2, mk(64'd0, 1'b0, 3'd2, 1'b1), 1'b1);
        send(MINU, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, mk(64'd0, 1'b0, 3'd3, 1'b1), 1'b1);
`endif
        wait_drain();
        // XLEN=32, STAGES=1 instance: word ops are illegal, plain ops work.
        bus32.in_valid_i = 1'b1; bus32.op_i = ADDW;
        bus32.operand_a_i = 32'd1; bus32.operand_b_i = 32'd2; bus32.trans_id_i = 3'd3;
        step();
        bus32.op_i = ADD; bus32.operand_a_i = 32'hFFFF_FFFF; bus32.operand_b_i = 32'd2; bus32.trans_id_i = 3'd4;
        @(negedge clk);
        checks++;
        if (bus32.out_valid_o !== 1'b1 || bus32.illegal_o !== 1'b1 || bus32.result_o !== 32'd0 || bus32.trans_id_o !== 3'd3) begin
            errors++;
            $display("FAIL x32_addw: vld=%b ill=%b res=%h tid=%0d, required 1 1 0 3",
                     bus32.out_valid_o, bus32.illegal_o, bus32.result_o, bus32.trans_id_o);
        end
        step();
        bus32.in_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus32.out_valid_o !== 1'b1 || bus32.illegal_o !== 1'b0 || bus32.result_o !== 32'd1) begin
            errors++;
            $display("FAIL x32_add: vld=%b ill=%b res=%h, required 1 0 00000001",
                     bus32.out_valid_o, bus32.illegal_o, bus32.result_o);
        end
        step();
    endtask

    initial begin
        ez = mk(64'd0, 1'b0, 3'd0, 1'b0);
        bus.in_valid_i = 1'b0; bus.op_i = ADD; bus.operand_a_i = '0; bus.operand_b_i = '0;
        bus.trans_id_i = '0; bus.out_ready_i = 1'b1;
        bus32.in_valid_i = 1'b0; bus32.op_i = ADD; bus32.operand_a_i = '0; bus32.operand_b_i = '0;
        bus32.trans_id_i = '0; bus32.out_ready_i = 1'b1;
        test_reset();
        test_streaming();
        test_word_ops();
        test_branch();
        test_backpressure();
        test_back_to_back();
        test_flush_reset();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
